rr_stream_arbiter: RTL and testbench

//  Merges NUM_REQ valid/ready word streams into one registered output stream that

---
 rtl/rr_stream_arbiter.sv | 153 +++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin stream arbiter with optional burst lock.
// Merges NUM_REQ valid/ready word streams into one registered output stream.
module rr_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
  input  logic [NUM_REQ-1:0]            din_v,
  output logic [NUM_REQ-1:0]            din_r,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_v,
  input  logic                          dout_r,
  output logic [IDX_WIDTH-1:0]          dout_sel
);

  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_WIDTH-1:0]    owner_reg, owner_next;
  logic [CNT_WIDTH-1:0]    burst_cnt_reg, burst_cnt_next;
  logic [IDX_WIDTH-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [DATA_WIDTH-1:0]   dout_reg;
  logic                    dout_v_reg;
  logic [IDX_WIDTH-1:0]    dout_sel_reg;

  logic                    load_en;
  logic                    keep;
  logic [IDX_WIDTH-1:0]    search_start;
  logic                    hit;
  logic [IDX_WIDTH-1:0]    hit_idx;
  logic                    grant_any;
  logic [IDX_WIDTH-1:0]    grant_idx;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      owner_match;
  logic [NUM_REQ-1:0]      hi_v;
  logic [CNT_WIDTH-1:0]    burst_inc;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Priority chains: lowest valid index at/after search_start, and lowest valid overall.
  logic                    hi_found  [NUM_REQ+1];
  logic [IDX_WIDTH-1:0]    hi_idx    [NUM_REQ+1];
  logic                    all_found [NUM_REQ+1];
  logic [IDX_WIDTH-1:0]    all_idx   [NUM_REQ+1];
  logic [DATA_WIDTH-1:0]   data_or   [NUM_REQ+1];

  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  assign load_en      = ~dout_v_reg | dout_r;
  assign keep         = (state_reg == BURST) & (|owner_match);
  // A released lock resumes the search just past the old owner.
  assign search_start = (state_reg == BURST) ? wrap_inc(owner_reg) : rr_ptr_reg;

  assign hi_found[0]  = 1'b0;
  assign hi_idx[0]    = '0;
  assign all_found[0] = 1'b0;
  assign all_idx[0]   = '0;
  assign data_or[0]   = '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    localparam logic [IDX_WIDTH-1:0] GI = IDX_WIDTH'(gi);

    assign owner_match[gi]  = din_v[gi] & (owner_reg == GI);
    assign hi_v[gi]         = din_v[gi] & (GI >= search_start);

    assign hi_found[gi+1]   = hi_found[gi] | hi_v[gi];
    assign hi_idx[gi+1]     = hi_found[gi] ? hi_idx[gi] : GI;
    assign all_found[gi+1]  = all_found[gi] | din_v[gi];
    assign all_idx[gi+1]    = all_found[gi] ? all_idx[gi] : GI;

    assign grant[gi]        = grant_any & (grant_idx == GI);
    assign data_or[gi+1]    = data_or[gi] |
                              (din[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[gi]}});
  end

  assign hit        = all_found[NUM_REQ];
  assign hit_idx    = hi_found[NUM_REQ] ? hi_idx[NUM_REQ] : all_idx[NUM_REQ];
  assign grant_any  = keep | hit;
  assign grant_idx  = keep ? owner_reg : hit_idx;
  assign grant_data = data_or[NUM_REQ];
  assign burst_inc  = burst_cnt_reg + 1'b1;

  // Reset also masks the accept strobes combinationally so they drop at once.
  assign din_r = (load_en & ~reset) ? grant : '0;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (load_en) begin
      if (keep) begin
        burst_cnt_next = burst_inc;
        if (burst_inc == BURST_MAX) begin
          rr_ptr_next = wrap_inc(owner_reg);
          state_next  = IDLE;
        end
      end else begin
        if (state_reg == BURST) begin
          rr_ptr_next = wrap_inc(owner_reg);
          state_next  = IDLE;
        end
        if (hit) begin
          if (BURST_LEN == 1) begin
            rr_ptr_next = wrap_inc(hit_idx);
          end else begin
            owner_next     = hit_idx;
            burst_cnt_next = CNT_WIDTH'(1);
            state_next     = BURST;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      rr_ptr_reg    <= '0;
      dout_reg      <= '0;
      dout_v_reg    <= 1'b0;
      dout_sel_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      if (load_en) begin
        dout_v_reg <= grant_any;
        if (grant_any) begin
          dout_reg     <= grant_data;
          dout_sel_reg <= grant_idx;
        end
      end
    end
  end

  assign dout     = dout_reg;
  assign dout_v   = dout_v_reg;
  assign dout_sel = dout_sel_reg;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench for rr_stream_arbiter: three configurations share one stimulus,
// a reference model predicts grants and a monitor checks every word leaving dout.
module tb_rr_stream_arbiter;
  localparam int DW = 32;
  localparam int NI = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [4*DW-1:0] din   = '0;
  logic [3:0]      din_v = '0;
  logic            dout_r = 1'b0;

  logic [3:0]    dr0, dr1;
  logic [2:0]    dr2;
  logic [DW-1:0] dq0, dq1, dq2;
  logic          dv0, dv1, dv2;
  logic [1:0]    ds0, ds1, ds2;

  always #5 clock = ~clock;

  rr_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(4), .IDX_WIDTH(2), .BURST_LEN(4)) u_b4 (
    .clock(clock), .reset(reset), .din(din), .din_v(din_v), .din_r(dr0),
    .dout(dq0), .dout_v(dv0), .dout_r(dout_r), .dout_sel(ds0));
  rr_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(4), .IDX_WIDTH(2), .BURST_LEN(1)) u_b1 (
    .clock(clock), .reset(reset), .din(din), .din_v(din_v), .din_r(dr1),
    .dout(dq1), .dout_v(dv1), .dout_r(dout_r), .dout_sel(ds1));
  rr_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3), .IDX_WIDTH(2), .BURST_LEN(2)) u_n3 (
    .clock(clock), .reset(reset), .din(din[3*DW-1:0]), .din_v(din_v[2:0]), .din_r(dr2),
    .dout(dq2), .dout_v(dv2), .dout_r(dout_r), .dout_sel(ds2));

  logic [3:0]    dr [NI];
  logic [DW-1:0] dq [NI];
  logic          dv [NI];
  logic [1:0]    ds [NI];
  always_comb begin
    dr[0] = dr0; dr[1] = dr1; dr[2] = {1'b0, dr2};
    dq[0] = dq0; dq[1] = dq1; dq[2] = dq2;
    dv[0] = dv0; dv[1] = dv1; dv[2] = dv2;
    ds[0] = ds0; ds[1] = ds1; ds[2] = ds2;
  end

  int checks   = 0;
  int failures = 0;
  bit verbose  = 1'b1;
  bit fixed_data = 1'b1;

  // Reference model state: next search start, lock owner (-1 = none), beats used.
  int          ptr  [NI];
  int          lock [NI];
  int          used [NI];
  bit          exp_vld [NI];
  int          wait_cnt [NI][4];
  logic [33:0] exp_q [NI][$];

  bit            stall_prev [NI];
  logic [DW-1:0] prev_q [NI];
  logic [1:0]    prev_s [NI];

  function automatic int nr(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic int bl(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
  endfunction

  task automatic check(input bit ok, input string name, input int k,
                       input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int n, b, g, start, limit;
    bit le;
    logic [3:0] exp_dr;
    n = nr(k);
    b = bl(k);
    g = -1;
    limit = (n - 1) * b + 1;
    if (reset) begin
      ptr[k] = 0; lock[k] = -1; used[k] = 0; exp_vld[k] = 1'b0;
      exp_q[k].delete();
      for (int i = 0; i < 4; i++) wait_cnt[k][i] = 0;
      return;
    end
    check(dv[k] === exp_vld[k], "dout_v", k, longint'(dv[k]), longint'(exp_vld[k]));
    le = !exp_vld[k] || dout_r;
    if (le) begin
      if (lock[k] >= 0 && din_v[lock[k]]) begin
        g = lock[k];
        used[k]++;
        if (used[k] == b) begin
          ptr[k]  = (g + 1) % n;
          lock[k] = -1;
        end
      end else begin
        if (lock[k] >= 0) begin
          ptr[k]  = (lock[k] + 1) % n;
          lock[k] = -1;
        end
        start = ptr[k];
        for (int j = 0; j < n; j++)
          if (g < 0 && din_v[(start + j) % n]) g = (start + j) % n;
        if (g >= 0) begin
          if (b == 1) ptr[k] = (g + 1) % n;
          else begin
            lock[k] = g;
            used[k] = 1;
          end
        end
      end
    end
    exp_dr = (g >= 0) ? 4'(1 << g) : 4'd0;
    check(dr[k] === exp_dr, "din_r", k, longint'(dr[k]), longint'(exp_dr));
    if (le) begin
      for (int i = 0; i < n; i++) begin
        if (din_v[i]) begin
          if (g == i) begin
            check(wait_cnt[k][i] < limit, "fairness_wait", k, longint'(wait_cnt[k][i]), longint'(limit));
            wait_cnt[k][i] = 0;
          end else begin
            wait_cnt[k][i]++;
          end
        end else begin
          wait_cnt[k][i] = 0;
        end
      end
      exp_vld[k] = (g >= 0);
      if (g >= 0) exp_q[k].push_back({2'(g), din[g*DW +: DW]});
    end
  endtask

  task automatic monitor_step(input int k);
    logic [33:0] e;
    if (reset) begin
      stall_prev[k] = 1'b0;
      return;
    end
    if (stall_prev[k]) begin
      check(dq[k] === prev_q[k], "stall_dout", k, longint'(dq[k]), longint'(prev_q[k]));
      check(ds[k] === prev_s[k], "stall_sel", k, longint'(ds[k]), longint'(prev_s[k]));
    end
    if (dv[k] === 1'b1 && dout_r) begin
      if (exp_q[k].size() == 0) begin
        check(1'b0, "unexpected_word", k, longint'(dq[k]), 0);
      end else begin
        e = exp_q[k].pop_front();
        check(dq[k] === e[31:0], "dout", k, longint'(dq[k]), longint'(e[31:0]));
        check(ds[k] === e[33:32], "dout_sel", k, longint'(ds[k]), longint'(e[33:32]));
        if (verbose)
          $display("txn inst=%0d sel=%0d data=%08h t=%0t", k, ds[k], dq[k], $time);
      end
    end
    stall_prev[k] = (dv[k] === 1'b1) && !dout_r;
    prev_q[k] = dq[k];
    prev_s[k] = ds[k];
  endtask

  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) monitor_step(k);
    end
  end

  task automatic set_data();
    for (int i = 0; i < 4; i++)
      din[i*DW +: DW] = fixed_data ? (32'hA0 + 32'(i)) : 32'($urandom);
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    @(posedge clock);
    #1;
    din_v  = v;
    dout_r = r;
    set_data();
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rv;
    din_v  = 4'hF;
    dout_r = 1'b1;
    set_data();
    #12;
    for (int k = 0; k < NI; k++) begin
      check(dv[k] === 1'b0, "reset_dout_v", k, longint'(dv[k]), 0);
      check(dr[k] === 4'd0, "reset_din_r", k, longint'(dr[k]), 0);
      check(dq[k] === '0, "reset_dout", k, longint'(dq[k]), 0);
      check(ds[k] === 2'd0, "reset_dout_sel", k, longint'(ds[k]), 0);
    end
    release_reset();

    // All requesters valid with fixed words: plain RR and burst ordering.
    repeat (10) step(4'hF, 1'b1);

    // Asynchronous reset while the burst instance is mid-burst with dout_v high.
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check(dv[k] === 1'b0, "async_rst_dout_v", k, longint'(dv[k]), 0);
      check(dr[k] === 4'd0, "async_rst_din_r", k, longint'(dr[k]), 0);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) step(4'hF, 1'b1);

    // Owner drops mid-burst while another requester waits.
    repeat (2) step(4'b0001, 1'b1);
    repeat (3) step(4'b0100, 1'b1);

    // Output stall, then release.
    repeat (5) step(4'hF, 1'b0);
    repeat (3) step(4'hF, 1'b1);

    // Highest index alone, then wrap contention.
    step(4'b1000, 1'b1);
    repeat (3) step(4'b1001, 1'b1);
    step(4'b0000, 1'b1);

    verbose    = 1'b0;
    fixed_data = 1'b0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, 9) < 6);
      step(rv, ($urandom_range(0, 3) != 0));
    end

    repeat (4) step(4'b0000, 1'b1);
    @(negedge clock);
    #1;
    for (int k = 0; k < NI; k++)
      check(exp_q[k].size() == 0, "drain_empty", k, longint'(exp_q[k].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
